alu_mc: RTL and testbench

Multi-cycle, parametrised successor to the single-cycle ALU in the CPU datapath. It accepts one operation at a time over a valid/ready handshake and registers the result and flags. It adds XOR/NOR/SLTU/shifts and an iterative unsigned multiplier that produces a double-width product. It sits between the decode/issue stage and writeback, so the pipeline can stall on long operations instead of stretching the cycle.

---
 rtl/alu_mc_if.sv | 26 ++
 rtl/alu_mc.sv | 144 ++++++++++++++
 tb/tb_alu_mc.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
// Request/response bundle for alu_mc. The master side issues operations
// and consumes results; the slave side is the ALU.
interface alu_mc_if #(parameter int DATA_WIDTH = 32);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic [3:0]            ALUop;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] Result;
    logic [DATA_WIDTH-1:0] ResultHi;
    logic                  Overflow;
    logic                  CarryOut;
    logic                  Zero;

    modport master (
        output in_valid, A, B, ALUop, out_ready,
        input  in_ready, out_valid, Result, ResultHi, Overflow, CarryOut, Zero
    );

    modport slave (
        input  in_valid, A, B, ALUop, out_ready,
        output in_ready, out_valid, Result, ResultHi, Overflow, CarryOut, Zero
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: one operation at a time, registered result and flags,
// iterative shift-add unsigned multiplier producing a double-width product.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a request; operands latched on accept
// EXEC  | compute/register result from latched operands (or finished product)
// MUL   | one shift-add step per cycle, cnt counts down to 0
// DONE  | out_valid=1, holding result until out_ready
module alu_mc #(
    parameter int DATA_WIDTH = 32
) (
    input logic     clk,
    input logic     rst,
    alu_mc_if.slave bus
);
    localparam int W       = DATA_WIDTH;
    localparam int SHAMT_W = $clog2(DATA_WIDTH);
    localparam logic [3:0] OP_MULU = 4'b1100;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t             state;
    logic [W-1:0]       op_a, op_b, acc_hi, acc_lo;
    logic [3:0]         op_code;
    logic [SHAMT_W-1:0] cnt;
    logic               in_ready_q, out_valid_q;
    logic [W-1:0]       result_q, result_hi_q;
    logic               ov_q, co_q, zero_q;

    logic [W:0]         sum_add, sum_sub, sum_mul;
    logic [SHAMT_W-1:0] shamt;
    logic               ov_add, ov_sub, known_op;
    logic [W-1:0]       alu_res;
    logic               alu_ov, alu_co;

    always_comb begin
        sum_add  = {1'b0, op_a} + {1'b0, op_b};
        sum_sub  = {1'b0, op_a} + {1'b0, ~op_b} + {{W{1'b0}}, 1'b1};
        ov_add   = (op_a[W-1] == op_b[W-1]) && (sum_add[W-1] != op_a[W-1]);
        ov_sub   = (op_a[W-1] != op_b[W-1]) && (sum_sub[W-1] != op_a[W-1]);
        shamt    = op_b[SHAMT_W-1:0];
        alu_res  = '0;
        alu_ov   = 1'b0;
        alu_co   = 1'b0;
        known_op = 1'b1;
        case (op_code)
            4'b0000: alu_res = op_a & op_b;
            4'b0001: alu_res = op_a | op_b;
            4'b0010: begin
                alu_res = sum_add[W-1:0];
                alu_co  = sum_add[W];
                alu_ov  = ov_add;
            end
            4'b0011: alu_res = op_a ^ op_b;
            4'b0100: alu_res = ~(op_a | op_b);
            4'b0101: alu_res = {{(W-1){1'b0}}, ~sum_sub[W]};
            4'b0110: begin
                alu_res = sum_sub[W-1:0];
                alu_co  = ~sum_sub[W];   // no carry out of A+~B+1 means borrow
                alu_ov  = ov_sub;
            end
            4'b0111: alu_res = {{(W-1){1'b0}}, sum_sub[W-1] ^ ov_sub};
            4'b1000: alu_res = op_a << shamt;
            4'b1001: alu_res = op_a >> shamt;
            4'b1010: alu_res = $signed(op_a) >>> shamt;
            default: known_op = 1'b0;
        endcase
        sum_mul = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_a} : {(W+1){1'b0}});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            op_code     <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            ov_q        <= 1'b0;
            co_q        <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    op_a       <= bus.A;
                    op_b       <= bus.B;
                    op_code    <= bus.ALUop;
                    in_ready_q <= 1'b0;
                    if (bus.ALUop == OP_MULU) begin
                        acc_hi <= '0;
                        acc_lo <= bus.B;
                        cnt    <= SHAMT_W'(W - 1);
                        state  <= MUL;
                    end else begin
                        state  <= EXEC;
                    end
                end
                MUL: begin
                    // {carry, acc_hi, acc_lo} >> 1 after the conditional add
                    acc_hi <= sum_mul[W:1];
                    acc_lo <= {sum_mul[0], acc_lo[W-1:1]};
                    if (cnt == '0) state <= EXEC;
                    else           cnt   <= cnt - SHAMT_W'(1);
                end
                EXEC: begin
                    if (op_code == OP_MULU) begin
                        result_q    <= acc_lo;
                        result_hi_q <= acc_hi;
                        ov_q        <= 1'b0;
                        co_q        <= 1'b0;
                        zero_q      <= ({acc_hi, acc_lo} == '0);
                    end else begin
                        result_q    <= alu_res;
                        result_hi_q <= '0;
                        ov_q        <= alu_ov;
                        co_q        <= alu_co;
                        zero_q      <= known_op && (alu_res == '0);
                    end
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.Result    = result_q;
    assign bus.ResultHi  = result_hi_q;
    assign bus.Overflow  = ov_q;
    assign bus.CarryOut  = co_q;
    assign bus.Zero      = zero_q;
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at widths 32 and 8: directed corner cases plus random
// operations compared with an arithmetic reference model.
module tb_alu_mc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_mc_if #(.DATA_WIDTH(32)) bus32 ();
    alu_mc_if #(.DATA_WIDTH(8))  bus8 ();

    alu_mc #(.DATA_WIDTH(32)) u_alu32 (.clk(clk), .rst(rst), .bus(bus32));
    alu_mc #(.DATA_WIDTH(8))  u_alu8  (.clk(clk), .rst(rst), .bus(bus8));

    localparam int ND = 16;
    logic [3:0]  d_op  [ND] = '{4'h2, 4'h6, 4'h6, 4'h7, 4'h5, 4'h7, 4'hA, 4'h9,
                                4'h8, 4'hC, 4'hC, 4'hB, 4'h0, 4'h1, 4'h3, 4'h4};
    logic [31:0] d_a   [ND] = '{32'h7FFFFFFF, 32'h0, 32'h5, 32'h80000000, 32'h80000000,
                                32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h1,
                                32'hFFFFFFFF, 32'h0, 32'h5, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                32'hFF00FF00, 32'h0000FFFF};
    logic [31:0] d_b   [ND] = '{32'h1, 32'h1, 32'h5, 32'h1, 32'h1, 32'hFFFFFFFF,
                                32'h21, 32'h21, 32'h1F, 32'hFFFFFFFF, 32'h1234, 32'h3,
                                32'h0FF00FF0, 32'h0F0F0F0F, 32'h0FF00FF0, 32'h00FF0000};
    logic [31:0] d_exp [ND] = '{32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h0, 32'h0,
                                32'hC0000000, 32'h40000000, 32'h80000000, 32'h1, 32'h0,
                                32'h0, 32'h00F000F0, 32'hFFFFFFFF, 32'hF0F0F0F0,
                                32'hFF000000};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on the operand values.
    task automatic model(input int w, input logic [3:0] op, input logic [63:0] a_in,
                         input logic [63:0] b_in, output logic [63:0] res,
                         output logic [63:0] hi, output logic ov, output logic co,
                         output logic z);
        logic [63:0] mask, a, b, p;
        longint sa, sb, t, maxs, mins, r;
        int sh;
        mask = (64'd1 << w) - 64'd1;
        a = a_in & mask;
        b = b_in & mask;
        sa = longint'(a) - (a[w-1] ? (longint'(1) << w) : longint'(0));
        sb = longint'(b) - (b[w-1] ? (longint'(1) << w) : longint'(0));
        maxs = (longint'(1) << (w - 1)) - 1;
        mins = -(longint'(1) << (w - 1));
        sh = int'(b % 64'(w));
        res = 0; hi = 0; ov = 0; co = 0;
        case (op)
            4'h0: res = a & b;
            4'h1: res = a | b;
            4'h2: begin
                res = (a + b) & mask;
                co = ((a + b) >> w) != 0;
                t = sa + sb;
                ov = (t > maxs) || (t < mins);
            end
            4'h3: res = a ^ b;
            4'h4: res = ~(a | b) & mask;
            4'h5: res = (a < b) ? 64'd1 : 64'd0;
            4'h6: begin
                res = (a - b) & mask;
                co = a < b;
                t = sa - sb;
                ov = (t > maxs) || (t < mins);
            end
            4'h7: res = (sa < sb) ? 64'd1 : 64'd0;
            4'h8: res = (a << sh) & mask;
            4'h9: res = a >> sh;
            4'hA: begin
                r = sa >>> sh;
                res = 64'(r) & mask;
            end
            4'hC: begin
                p = a * b;
                res = p & mask;
                hi = p >> w;
            end
            default: res = 0;
        endcase
        if (op == 4'hB || op == 4'hD || op == 4'hE || op == 4'hF) z = 1'b0;
        else z = (res == 0) && (hi == 0);
    endtask

    task automatic drive(input int w, input logic v, input logic [3:0] op,
                         input logic [63:0] a, input logic [63:0] b);
        if (w == 32) begin
            bus32.in_valid = v; bus32.ALUop = op; bus32.A = a[31:0]; bus32.B = b[31:0];
        end else begin
            bus8.in_valid = v; bus8.ALUop = op; bus8.A = a[7:0]; bus8.B = b[7:0];
        end
    endtask

    task automatic set_ordy(input int w, input logic v);
        if (w == 32) bus32.out_ready = v;
        else         bus8.out_ready = v;
    endtask

    function automatic logic get_irdy(input int w);
        return (w == 32) ? bus32.in_ready : bus8.in_ready;
    endfunction

    function automatic logic get_ovld(input int w);
        return (w == 32) ? bus32.out_valid : bus8.out_valid;
    endfunction

    task automatic sample(input int w, output logic [63:0] res, output logic [63:0] hi,
                          output logic ov, output logic co, output logic z);
        if (w == 32) begin
            res = 64'(bus32.Result); hi = 64'(bus32.ResultHi);
            ov = bus32.Overflow; co = bus32.CarryOut; z = bus32.Zero;
        end else begin
            res = 64'(bus8.Result); hi = 64'(bus8.ResultHi);
            ov = bus8.Overflow; co = bus8.CarryOut; z = bus8.Zero;
        end
    endtask

    // One full transaction; operands are scrambled right after acceptance.
    task automatic run_op(input int w, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input int hold, output logic [63:0] res_o);
        logic [63:0] e_res, e_hi, o_res, o_hi;
        logic e_ov, e_co, e_z, o_ov, o_co, o_z;
        int k, lat;
        model(w, op, a, b, e_res, e_hi, e_ov, e_co, e_z);
        k = 0;
        while (!get_irdy(w) && k < 100) begin @(posedge clk); #1; k++; end
        check("in_ready_before_req", 64'(get_irdy(w)), 64'd1);
        drive(w, 1'b1, op, a, b);
        @(posedge clk); #1;
        drive(w, 1'b0, 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        check("in_ready_after_accept", 64'(get_irdy(w)), 64'd0);
        lat = 0;
        while (!get_ovld(w) && lat < 200) begin @(posedge clk); #1; lat++; end
        check("latency", 64'(lat), (op == 4'hC) ? 64'(w + 1) : 64'd1);
        sample(w, o_res, o_hi, o_ov, o_co, o_z);
        check("result", o_res, e_res);
        check("result_hi", o_hi, e_hi);
        check("overflow", 64'(o_ov), 64'(e_ov));
        check("carryout", 64'(o_co), 64'(e_co));
        check("zero", 64'(o_z), 64'(e_z));
        res_o = o_res;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            sample(w, o_res, o_hi, o_ov, o_co, o_z);
            check("hold_result", o_res, e_res);
            check("hold_in_ready", 64'(get_irdy(w)), 64'd0);
            check("hold_out_valid", 64'(get_ovld(w)), 64'd1);
        end
        set_ordy(w, 1'b1);
        @(posedge clk); #1;
        set_ordy(w, 1'b0);
        check("out_valid_after_hs", 64'(get_ovld(w)), 64'd0);
        check("in_ready_after_hs", 64'(get_irdy(w)), 64'd1);
    endtask

    initial begin
        logic [63:0] r, hi_v;
        logic ov_v, co_v, z_v;
        drive(32, 1'b0, 4'h0, 64'd0, 64'd0);
        drive(8, 1'b0, 4'h0, 64'd0, 64'd0);
        set_ordy(32, 1'b0);
        set_ordy(8, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        foreach (d_op[i]) begin end
        check("rst_in_ready32", 64'(bus32.in_ready), 64'd1);
        check("rst_out_valid32", 64'(bus32.out_valid), 64'd0);
        check("rst_result8", 64'(bus8.Result), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < ND; i++) begin
            run_op(32, d_op[i], 64'(d_a[i]), 64'(d_b[i]), 0, r);
            check("directed_const", r, 64'(d_exp[i]));
        end
        check("mulu_hi_const", 64'(bus32.ResultHi), 64'd0);

        run_op(32, 4'hC, 64'hFFFFFFFF, 64'hFFFFFFFF, 0, r);
        check("mulu_max_hi", 64'(bus32.ResultHi), 64'hFFFFFFFE);

        // Backpressure, then the next op must be accepted right after the handshake.
        run_op(32, 4'h2, 64'h12345678, 64'h11111111, 10, r);
        run_op(32, 4'hC, 64'h0000BEEF, 64'h00001234, 0, r);

        for (int i = 0; i < 40; i++)
            run_op(32, 4'($urandom_range(0, 15)), 64'($urandom), 64'($urandom), 0, r);
        for (int i = 0; i < 40; i++)
            run_op(8, (i % 2 == 0) ? 4'h2 : 4'hC, 64'($urandom), 64'($urandom), 0, r);
        for (int i = 0; i < 30; i++)
            run_op(8, 4'($urandom_range(0, 15)), 64'($urandom), 64'($urandom), 0, r);

        // Asynchronous reset three cycles into a multiply.
        drive(32, 1'b1, 4'hC, 64'hDEADBEEF, 64'h12345678);
        @(posedge clk); #1;
        drive(32, 1'b0, 4'h0, 64'd0, 64'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        sample(32, r, hi_v, ov_v, co_v, z_v);
        check("arst_out_valid", 64'(bus32.out_valid), 64'd0);
        check("arst_in_ready", 64'(bus32.in_ready), 64'd1);
        check("arst_result", r, 64'd0);
        check("arst_result_hi", hi_v, 64'd0);
        check("arst_flags", {61'd0, ov_v, co_v, z_v}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32, 4'hC, 64'h00010001, 64'h00020003, 0, r);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
